// File: rtl/store_packer.sv
// -----------------------------------------------------------------------------
// store_packer
// Turns an sb/sh/sw store request into accesses on a word-wide data memory
// that has no byte enables. Word stores are written straight through. Byte
// and halfword stores read the containing word, splice the new lane(s) in and
// write the word back. Misaligned or illegal requests are rejected before any
// memory access. A memory phase that never sees mem_ack is aborted after
// TIMEOUT cycles.
//
// Ports
//   clk, rstn            clock (rising edge), asynchronous active-low reset
//   st_req               store request, accepted only while st_ready=1
//   st_addr/st_data      byte address and rt register value
//   st_size              0=byte, 1=half, 2=word, 3=illegal
//   st_ready             idle, can accept a request
//   st_done / st_err     one-cycle completion / abort pulses
//   mem_addr             word-aligned memory address
//   mem_rd / mem_wr      read / write strobes, held until mem_ack
//   mem_wdata            merged write word
//   mem_rdata, mem_ack   read data and completion from memory
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | ready for a request; request fields latched on st_req
// CHK    | one cycle of alignment/size checking
// RD     | reading the containing word for a byte/half store
// WR     | writing the (merged) word
// DONE   | st_done pulse
// ERR    | st_err pulse (misaligned, illegal size or memory timeout)
// -----------------------------------------------------------------------------
module store_packer #(
    parameter bit BIG_ENDIAN = 1'b0,
    parameter int TIMEOUT    = 16
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        st_req,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_data,
    input  logic [1:0]  st_size,
    output logic        st_ready,
    output logic        st_done,
    output logic        st_err,
    output logic [31:0] mem_addr,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHK,
        S_RD,
        S_WR,
        S_DONE,
        S_ERR
    } state_t;

    // The counter only ever has to hold 0..TIMEOUT-1.
    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    state_t         state_q, state_d;
    logic [31:0]    data_q, data_d;
    logic [1:0]     size_q, size_d;
    logic [1:0]     lane_q, lane_d;
    logic [31:0]    mem_addr_q, mem_addr_d;
    logic [31:0]    mem_wdata_q, mem_wdata_d;
    logic [CW-1:0]  cnt_q, cnt_d;

    logic           bad_req;
    logic [4:0]     shamt;
    logic [31:0]    lane_mask;
    logic [31:0]    lane_val;
    logic [31:0]    merged;

    assign bad_req = (size_q == 2'd3)
                  || ((size_q == 2'd1) && lane_q[0])
                  || ((size_q == 2'd2) && (lane_q != 2'd0));

    // Lane placement: little-endian puts byte k at bit 8k, big-endian at
    // bit 8*(3-k); ~lane is 3-k for a 2-bit lane index.
    always_comb begin
        shamt     = 5'd0;
        lane_mask = 32'h0000_00FF;
        lane_val  = {24'b0, data_q[7:0]};
        if (size_q == 2'd0) begin
            shamt = BIG_ENDIAN ? {~lane_q, 3'b000} : {lane_q, 3'b000};
        end else begin
            lane_mask = 32'h0000_FFFF;
            lane_val  = {16'b0, data_q[15:0]};
            shamt     = BIG_ENDIAN ? {~lane_q[1], 4'b0000} : {lane_q[1], 4'b0000};
        end
        merged = (mem_rdata & ~(lane_mask << shamt)) | (lane_val << shamt);
    end

    always_comb begin
        state_d     = state_q;
        data_d      = data_q;
        size_d      = size_q;
        lane_d      = lane_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        cnt_d       = cnt_q;

        case (state_q)
            S_IDLE: begin
                if (st_req) begin
                    data_d     = st_data;
                    size_d     = st_size;
                    lane_d     = st_addr[1:0];
                    mem_addr_d = {st_addr[31:2], 2'b00};
                    state_d    = S_CHK;
                end
            end
            S_CHK: begin
                cnt_d = '0;
                if (bad_req) begin
                    state_d = S_ERR;
                end else if (size_q == 2'd2) begin
                    mem_wdata_d = data_q;
                    state_d     = S_WR;
                end else begin
                    state_d = S_RD;
                end
            end
            S_RD: begin
                if (mem_ack) begin
                    mem_wdata_d = merged;
                    cnt_d       = '0;
                    state_d     = S_WR;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_ERR;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_WR: begin
                if (mem_ack) begin
                    state_d = S_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_ERR;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= S_IDLE;
            data_q      <= '0;
            size_q      <= '0;
            lane_q      <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            size_q      <= size_d;
            lane_q      <= lane_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cnt_q       <= cnt_d;
        end
    end

    // All handshake outputs are decoded from state, so an async reset drops
    // the strobes immediately.
    assign st_ready  = (state_q == S_IDLE);
    assign st_done   = (state_q == S_DONE);
    assign st_err    = (state_q == S_ERR);
    assign mem_rd    = (state_q == S_RD);
    assign mem_wr    = (state_q == S_WR);
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_store_packer.sv
module tb_store_packer;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        st_req = 1'b0;
    logic [31:0] st_addr = '0;
    logic [31:0] st_data = '0;
    logic [1:0]  st_size = '0;
    logic [31:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;

    logic        st_ready, st_done, st_err, mem_rd, mem_wr;
    logic [31:0] mem_addr, mem_wdata;
    logic        be_st_ready, be_st_done, be_st_err, be_mem_rd, be_mem_wr;
    logic [31:0] be_mem_addr, be_mem_wdata;

    int errors = 0;
    int checks = 0;

    // observations of the last run_store
    int          n_rd, n_wr, n_done, n_err, done_cyc, err_cyc;
    logic [31:0] rd_addr, wr_addr, wr_data, be_wr_data;
    bit          both, unstable, ready_c1, ready_after, fin;

    always #5 clk = ~clk;

    store_packer #(.BIG_ENDIAN(1'b0), .TIMEOUT(8)) dut (
        .clk(clk), .rstn(rstn), .st_req(st_req), .st_addr(st_addr),
        .st_data(st_data), .st_size(st_size), .st_ready(st_ready),
        .st_done(st_done), .st_err(st_err), .mem_addr(mem_addr),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    store_packer #(.BIG_ENDIAN(1'b1), .TIMEOUT(8)) dut_be (
        .clk(clk), .rstn(rstn), .st_req(st_req), .st_addr(st_addr),
        .st_data(st_data), .st_size(st_size), .st_ready(be_st_ready),
        .st_done(be_st_done), .st_err(be_st_err), .mem_addr(be_mem_addr),
        .mem_rd(be_mem_rd), .mem_wr(be_mem_wr), .mem_wdata(be_mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    // Issue one request and play memory. rd_wait/wr_wait = number of cycles
    // the strobe is seen before ack (0 = ack in first cycle, -1 = never).
    // Called at posedge+1 in an idle cycle; returns at posedge+1.
    task automatic run_store(input logic [31:0] a, input logic [31:0] d,
                             input logic [1:0] sz, input logic [31:0] rdata,
                             input int rd_wait, input int wr_wait);
        int rd_seen = 0;
        int wr_seen = 0;
        n_rd = 0; n_wr = 0; n_done = 0; n_err = 0; done_cyc = -1; err_cyc = -1;
        rd_addr = '0; wr_addr = '0; wr_data = '0; be_wr_data = '0;
        both = 0; unstable = 0; ready_c1 = 1; ready_after = 0; fin = 0;
        st_req = 1'b1; st_addr = a; st_data = d; st_size = sz;
        for (int c = 1; c <= 40 && !fin; c++) begin
            @(posedge clk); #1;
            // change the request fields: the block must use its latched copy
            st_req = 1'b0; st_addr = 32'hFFFF_FFFF; st_data = 32'h5A5A_5A5A; st_size = 2'd3;
            mem_ack = 1'b0; mem_rdata = 32'hCCCC_CCCC;
            if (c == 1) ready_c1 = st_ready;
            if ((mem_rd && mem_wr) || (st_done && st_err)) both = 1;
            if (mem_rd) begin
                rd_seen++; n_rd++; rd_addr = mem_addr;
                if (rd_wait >= 0 && rd_seen == rd_wait + 1) begin
                    mem_ack = 1'b1; mem_rdata = rdata;
                end
            end
            if (mem_wr) begin
                wr_seen++; n_wr++;
                if (wr_seen == 1) begin
                    wr_data = mem_wdata; wr_addr = mem_addr; be_wr_data = be_mem_wdata;
                end else if (mem_wdata !== wr_data || mem_addr !== wr_addr) begin
                    unstable = 1;
                end
                if (wr_wait >= 0 && wr_seen == wr_wait + 1) mem_ack = 1'b1;
            end
            if (st_done) begin n_done++; done_cyc = c; fin = 1; end
            if (st_err) begin n_err++; err_cyc = c; fin = 1; end
        end
        @(posedge clk); #1;
        mem_ack = 1'b0;
        ready_after = st_ready;
        if (st_done) n_done++;
        if (st_err) n_err++;
    endtask

    task automatic test_reset();
        checks++; if (st_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", st_ready); end
        checks++; if (st_done !== 1'b0 || st_err !== 1'b0) begin errors++; $display("FAIL reset_pulses: got done=%b err=%b expected 0 0", st_done, st_err); end
        checks++; if (mem_rd !== 1'b0 || mem_wr !== 1'b0) begin errors++; $display("FAIL reset_strobes: got rd=%b wr=%b expected 0 0", mem_rd, mem_wr); end
        checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h expected 00000000", mem_addr); end
        checks++; if (mem_wdata !== 32'h0) begin errors++; $display("FAIL reset_wdata: got %h expected 00000000", mem_wdata); end
    endtask

    task automatic test_subword();
        logic [31:0] t_addr[5] = '{32'h1001, 32'h1003, 32'h1000, 32'h1002, 32'h1000};
        logic [31:0] t_data[5] = '{32'h1234_56AB, 32'h1234_56AB, 32'h1234_56AB, 32'h9876_BEEF, 32'h9876_BEEF};
        logic [1:0]  t_size[5] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1};
        logic [31:0] t_le[5]   = '{32'h1122_AB44, 32'hAB22_3344, 32'h1122_33AB, 32'hBEEF_3344, 32'h1122_BEEF};
        logic [31:0] t_be[5]   = '{32'h11AB_3344, 32'h1122_33AB, 32'hAB22_3344, 32'h1122_BEEF, 32'hBEEF_3344};
        for (int i = 0; i < 5; i++) begin
            run_store(t_addr[i], t_data[i], t_size[i], 32'h1122_3344, 0, 0);
            checks++; if (ready_c1 !== 1'b0) begin errors++; $display("FAIL sub%0d_ready_busy: got %b expected 0", i, ready_c1); end
            checks++; if (n_rd != 1 || rd_addr !== 32'h1000) begin errors++; $display("FAIL sub%0d_read: got n=%0d addr=%h expected 1 00001000", i, n_rd, rd_addr); end
            checks++; if (n_wr != 1 || wr_addr !== 32'h1000) begin errors++; $display("FAIL sub%0d_write: got n=%0d addr=%h expected 1 00001000", i, n_wr, wr_addr); end
            checks++; if (wr_data !== t_le[i]) begin errors++; $display("FAIL sub%0d_wdata_le: got %h expected %h", i, wr_data, t_le[i]); end
            checks++; if (be_wr_data !== t_be[i]) begin errors++; $display("FAIL sub%0d_wdata_be: got %h expected %h", i, be_wr_data, t_be[i]); end
            checks++; if (done_cyc != 4 || n_done != 1 || n_err != 0) begin errors++; $display("FAIL sub%0d_done: got cyc=%0d n=%0d err=%0d expected 4 1 0", i, done_cyc, n_done, n_err); end
            checks++; if (ready_after !== 1'b1 || both) begin errors++; $display("FAIL sub%0d_end: got ready=%b both=%b expected 1 0", i, ready_after, both); end
        end
    endtask

    task automatic test_word_wait();
        run_store(32'h1004, 32'hDEAD_BEEF, 2'd2, 32'h0, 0, 3);
        checks++; if (n_rd != 0) begin errors++; $display("FAIL sw_no_read: got %0d expected 0", n_rd); end
        checks++; if (n_wr != 4 || unstable) begin errors++; $display("FAIL sw_wr_hold: got n=%0d unstable=%b expected 4 0", n_wr, unstable); end
        checks++; if (wr_data !== 32'hDEAD_BEEF || wr_addr !== 32'h1004) begin errors++; $display("FAIL sw_wdata: got %h@%h expected deadbeef@00001004", wr_data, wr_addr); end
        checks++; if (n_done != 1 || done_cyc != 6 || n_err != 0) begin errors++; $display("FAIL sw_done: got n=%0d cyc=%0d err=%0d expected 1 6 0", n_done, done_cyc, n_err); end
        checks++; if (ready_after !== 1'b1) begin errors++; $display("FAIL sw_ready: got %b expected 1", ready_after); end
    endtask

    task automatic test_errors();
        logic [31:0] t_addr[3] = '{32'h1001, 32'h1006, 32'h1000};
        logic [1:0]  t_size[3] = '{2'd1, 2'd2, 2'd3};
        for (int i = 0; i < 3; i++) begin
            run_store(t_addr[i], 32'h1234_5678, t_size[i], 32'h0, 0, 0);
            checks++; if (n_err != 1 || err_cyc != 2) begin errors++; $display("FAIL err%0d_pulse: got n=%0d cyc=%0d expected 1 2", i, n_err, err_cyc); end
            checks++; if (n_rd != 0 || n_wr != 0) begin errors++; $display("FAIL err%0d_no_access: got rd=%0d wr=%0d expected 0 0", i, n_rd, n_wr); end
            checks++; if (n_done != 0 || ready_after !== 1'b1) begin errors++; $display("FAIL err%0d_end: got done=%0d ready=%b expected 0 1", i, n_done, ready_after); end
        end
    endtask

    task automatic test_timeout();
        run_store(32'h1001, 32'h0000_00AB, 2'd0, 32'h1122_3344, -1, 0);
        checks++; if (n_rd != 8 || n_wr != 0) begin errors++; $display("FAIL to_rd_len: got rd=%0d wr=%0d expected 8 0", n_rd, n_wr); end
        checks++; if (n_err != 1 || err_cyc != 10 || n_done != 0) begin errors++; $display("FAIL to_rd_err: got n=%0d cyc=%0d done=%0d expected 1 10 0", n_err, err_cyc, n_done); end
        checks++; if (ready_after !== 1'b1) begin errors++; $display("FAIL to_rd_ready: got %b expected 1", ready_after); end
        run_store(32'h1001, 32'h0000_00AB, 2'd0, 32'h1122_3344, 7, 0);
        checks++; if (n_rd != 8 || n_wr != 1 || n_err != 0) begin errors++; $display("FAIL to_late_ack: got rd=%0d wr=%0d err=%0d expected 8 1 0", n_rd, n_wr, n_err); end
        checks++; if (done_cyc != 11 || wr_data !== 32'h1122_AB44) begin errors++; $display("FAIL to_late_done: got cyc=%0d wdata=%h expected 11 1122ab44", done_cyc, wr_data); end
        run_store(32'h1008, 32'hCAFE_F00D, 2'd2, 32'h0, 0, -1);
        checks++; if (n_wr != 8 || n_err != 1 || err_cyc != 10 || n_done != 0) begin errors++; $display("FAIL to_wr: got wr=%0d err=%0d cyc=%0d done=%0d expected 8 1 10 0", n_wr, n_err, err_cyc, n_done); end
    endtask

    task automatic test_reset_mid();
        bit saw_done = 0;
        st_req = 1'b1; st_addr = 32'h1004; st_data = 32'h0BAD_0BAD; st_size = 2'd2;
        @(posedge clk); #1;
        st_req = 1'b0;
        @(posedge clk); #1;
        checks++; if (mem_wr !== 1'b1) begin errors++; $display("FAIL rstmid_in_wr: got %b expected 1", mem_wr); end
        #2 rstn = 1'b0;
        #1;
        checks++; if (mem_wr !== 1'b0 || st_ready !== 1'b1) begin errors++; $display("FAIL rstmid_async: got wr=%b ready=%b expected 0 1", mem_wr, st_ready); end
        @(posedge clk); #3 rstn = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            if (st_done || st_err) saw_done = 1;
        end
        checks++; if (saw_done) begin errors++; $display("FAIL rstmid_no_pulse: got 1 expected 0"); end
        run_store(32'h1004, 32'h0123_4567, 2'd2, 32'h0, 0, 0);
        checks++; if (n_wr != 1 || wr_data !== 32'h0123_4567 || done_cyc != 3 || n_done != 1) begin errors++; $display("FAIL rstmid_after: got wr=%0d wdata=%h cyc=%0d n=%0d expected 1 01234567 3 1", n_wr, wr_data, done_cyc, n_done); end
    endtask

    initial begin
        #3;
        test_reset();
        #9 rstn = 1'b1;
        @(posedge clk); #1;
        test_subword();
        test_word_wait();
        test_errors();
        test_timeout();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
